// File: rtl/adc_sar_ctrl_if.sv
// Signal bundle between the SAR controller and the analog macro / host.
// Slave modport is the controller side; master modport is the macro/host side.
interface adc_sar_ctrl_if #(
    parameter int N = 12
);
    logic         start;
    logic         ms_rdy;
    logic         ms_cmp;
    logic         ms_clk;
    logic         ms_sample;
    logic [N-1:0] ms_dac;
    logic         busy;
    logic         valid;
    logic [N-1:0] data;
    logic         abort;

    modport master (
        output start, ms_rdy, ms_cmp,
        input  ms_clk, ms_sample, ms_dac, busy, valid, data, abort
    );

    modport slave (
        input  start, ms_rdy, ms_cmp,
        output ms_clk, ms_sample, ms_dac, busy, valid, data, abort
    );
endinterface

// File: rtl/adc_sar_ctrl.sv
// Successive-approximation ADC controller: track/hold, 2-cycle-per-bit binary search, result/abort pulses.
// Optional continuous mode is enabled by defining ADC_SAR_CTRL_CONT_EN (adds input cont).
module adc_sar_ctrl #(
    parameter int N          = 12,
    parameter int SAMPLE_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
`ifdef ADC_SAR_CTRL_CONT_EN
    input  logic cont,
`endif
    adc_sar_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    localparam logic [7:0]   SAMPLE_LAST = 8'(SAMPLE_CYC - 1);
    localparam logic [N-1:0] MSB_MASK    = {1'b1, {(N-1){1'b0}}};

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic         r_phase_b;
    logic [N-1:0] r_trial;
    logic [N-1:0] r_code;
    logic [N-1:0] r_dac;
    logic [N-1:0] r_data;
    logic         r_ms_clk;
    logic         r_sample;
    logic         r_busy;
    logic         r_valid;
    logic         r_abort;

    logic [N-1:0] w_keep;
    logic         w_cont;
    logic         w_rdy_lost;

`ifdef ADC_SAR_CTRL_CONT_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    // Code after the current bit decision: the trial bit takes the comparator result.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_keep
            assign w_keep[gi] = r_trial[gi] ? bus.ms_cmp : r_code[gi];
        end
    endgenerate

    assign w_rdy_lost = ((r_state == SAMPLE) || (r_state == CONVERT)) && !bus.ms_rdy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_phase_b <= 1'b0;
            r_trial   <= '0;
            r_code    <= '0;
            r_dac     <= '0;
            r_data    <= '0;
            r_ms_clk  <= 1'b0;
            r_sample  <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_abort <= 1'b0;
            if (w_rdy_lost) begin
                r_state  <= IDLE;
                r_abort  <= 1'b1;
                r_busy   <= 1'b0;
                r_sample <= 1'b0;
                r_ms_clk <= 1'b0;
                r_dac    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start && bus.ms_rdy) begin
                            r_state  <= SAMPLE;
                            r_sample <= 1'b1;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end
                    SAMPLE: begin
                        if (r_cnt == SAMPLE_LAST) begin
                            r_state   <= CONVERT;
                            r_sample  <= 1'b0;
                            r_code    <= '0;
                            r_trial   <= MSB_MASK;
                            r_dac     <= MSB_MASK;
                            r_ms_clk  <= 1'b1;
                            r_phase_b <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    CONVERT: begin
                        if (!r_phase_b) begin
                            // Falling strobe makes the comparator latch; decision is read at end of phase B.
                            r_ms_clk  <= 1'b0;
                            r_phase_b <= 1'b1;
                        end else begin
                            r_code    <= w_keep;
                            r_phase_b <= 1'b0;
                            if (r_trial[0]) begin
                                r_state <= DONE;
                                r_dac   <= '0;
                            end else begin
                                r_trial  <= r_trial >> 1;
                                r_dac    <= w_keep | (r_trial >> 1);
                                r_ms_clk <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_data  <= r_code;
                        r_valid <= 1'b1;
                        if (w_cont && bus.ms_rdy) begin
                            r_state  <= SAMPLE;
                            r_sample <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ms_clk    = r_ms_clk;
    assign bus.ms_sample = r_sample;
    assign bus.ms_dac    = r_dac;
    assign bus.busy      = r_busy;
    assign bus.valid     = r_valid;
    assign bus.data      = r_data;
    assign bus.abort     = r_abort;
endmodule
